// File: rtl/result_wb_ctrl.sv
// result_wb_ctrl: collects an FPU result burst into the result RAM, then reads it back and streams it out
module result_wb_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int MEM_DEPTH = 128
) (
  input  logic              wb_clk,
  input  logic              wb_reset_n,
  input  logic              wb_start,
  input  logic [ADDR_W-1:0] wb_length,
  input  logic              wb_res_valid,
  input  logic [DATA_W-1:0] wb_res_data,
  output logic              wb_res_ready,
  output logic [ADDR_W-1:0] wb_mem_address,
  output logic [DATA_W-1:0] wb_mem_data_in,
  output logic              wb_mem_we,
  input  logic [DATA_W-1:0] wb_mem_data_out,
  output logic [DATA_W-1:0] wb_out_data,
  output logic              wb_out_valid,
  input  logic              wb_out_ready,
  output logic              wb_done,
  output logic              wb_err
);
  typedef enum logic [2:0] {IDLE, COLLECT, RD_ADDR, RD_WAIT, OUT, DONE} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d, len_q, len_d, addr_d;
  logic [DATA_W-1:0] wdata_d, odata_d;
  logic ready_d, we_d, ovalid_d, done_d, err_d;
  logic len_ok, last_rd;
  // a burst longer than the RAM is refused like an empty one
  assign len_ok  = wb_length != '0 && {1'b0, wb_length} <= (ADDR_W+1)'(MEM_DEPTH);
  assign last_rd = rd_cnt == len_q - 1'b1;
  always_comb begin
    state_d  = state;
    wr_cnt_d = wr_cnt;
    rd_cnt_d = rd_cnt;
    len_d    = len_q;
    ready_d  = wb_res_ready;
    addr_d   = wb_mem_address;
    wdata_d  = wb_mem_data_in;
    we_d     = 1'b0;
    odata_d  = wb_out_data;
    ovalid_d = wb_out_valid;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE: if (wb_start) begin
        err_d = !len_ok;
        if (len_ok) begin
          len_d    = wb_length;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          ready_d  = 1'b1;
          state_d  = COLLECT;
        end
      end
      COLLECT: if (wb_res_valid && wb_res_ready) begin
        we_d     = 1'b1;
        addr_d   = wr_cnt;
        wdata_d  = wb_res_data;
        wr_cnt_d = wr_cnt + 1'b1;
        if (wr_cnt == len_q - 1'b1) begin
          ready_d  = 1'b0;
          rd_cnt_d = '0;
          state_d  = RD_ADDR;
        end
      end
      RD_ADDR: begin
        addr_d  = rd_cnt;
        state_d = RD_WAIT;
      end
      RD_WAIT: state_d = OUT;
      // first OUT cycle captures the RAM word; the word is then held until accepted
      OUT: if (!wb_out_valid) begin
        odata_d  = wb_mem_data_out;
        ovalid_d = 1'b1;
      end else if (wb_out_ready) begin
        ovalid_d = 1'b0;
        rd_cnt_d = rd_cnt + 1'b1;
        done_d   = last_rd;
        state_d  = last_rd ? DONE : RD_ADDR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state          <= IDLE;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      len_q          <= '0;
      wb_res_ready   <= 1'b0;
      wb_mem_address <= '0;
      wb_mem_data_in <= '0;
      wb_mem_we      <= 1'b0;
      wb_out_data    <= '0;
      wb_out_valid   <= 1'b0;
      wb_done        <= 1'b0;
      wb_err         <= 1'b0;
    end else begin
      state          <= state_d;
      wr_cnt         <= wr_cnt_d;
      rd_cnt         <= rd_cnt_d;
      len_q          <= len_d;
      wb_res_ready   <= ready_d;
      wb_mem_address <= addr_d;
      wb_mem_data_in <= wdata_d;
      wb_mem_we      <= we_d;
      wb_out_data    <= odata_d;
      wb_out_valid   <= ovalid_d;
      wb_done        <= done_d;
      wb_err         <= err_d;
    end
  end
endmodule

// File: tb/tb_result_wb_ctrl.sv
// tb_result_wb_ctrl: directed bursts against a behavioural result RAM
module tb_result_wb_ctrl;
  logic        wb_clk = 1'b0;
  logic        wb_reset_n = 1'b0;
  logic        wb_start = 1'b0;
  logic [6:0]  wb_length = '0;
  logic        wb_res_valid = 1'b0;
  logic [31:0] wb_res_data = '0;
  logic        wb_res_ready;
  logic [6:0]  wb_mem_address;
  logic [31:0] wb_mem_data_in;
  logic        wb_mem_we;
  logic [31:0] wb_mem_data_out;
  logic [31:0] wb_out_data;
  logic        wb_out_valid;
  logic        wb_out_ready = 1'b0;
  logic        wb_done;
  logic        wb_err;
  logic [31:0] ram [0:127];
  logic [31:0] want_q [0:127];
  int n_tests = 0;
  int n_fail = 0;

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) begin
    if (wb_mem_we) ram[wb_mem_address] <= wb_mem_data_in;
    wb_mem_data_out <= ram[wb_mem_address];
  end

  result_wb_ctrl dut (
    .wb_clk(wb_clk), .wb_reset_n(wb_reset_n), .wb_start(wb_start), .wb_length(wb_length),
    .wb_res_valid(wb_res_valid), .wb_res_data(wb_res_data), .wb_res_ready(wb_res_ready),
    .wb_mem_address(wb_mem_address), .wb_mem_data_in(wb_mem_data_in), .wb_mem_we(wb_mem_we),
    .wb_mem_data_out(wb_mem_data_out), .wb_out_data(wb_out_data), .wb_out_valid(wb_out_valid),
    .wb_out_ready(wb_out_ready), .wb_done(wb_done), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"}, wb_res_ready, 0);
    check({tag, "_addr"}, wb_mem_address, 0);
    check({tag, "_din"}, wb_mem_data_in, 0);
    check({tag, "_we"}, wb_mem_we, 0);
    check({tag, "_odata"}, wb_out_data, 0);
    check({tag, "_ovalid"}, wb_out_valid, 0);
    check({tag, "_done"}, wb_done, 0);
    check({tag, "_err"}, wb_err, 0);
  endtask

  // gap: valid offered every gap cycles; start_at: loop cycle of a stray start; abort2: reset while word 2 is shown
  task automatic run_burst(input int len, input int gap, input bit toggle_rdy, input int start_at,
                           input bit abort2, input logic [31:0] seed);
    int sent = 0, wr_seen = 0, rd_seen = 0, dones = 0;
    bit fin = 0, prev_stall = 0, last_hs = 0;
    logic [31:0] prev_data = '0;
    for (int i = 0; i < len; i++) want_q[i] = seed ^ (32'h0001_0003 * i);
    @(negedge wb_clk);
    wb_start = 1'b1;
    wb_length = 7'(len);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge wb_clk);
      if (last_hs) check("rdy_drop", wb_res_ready, 0);
      last_hs = 0;
      if (wb_mem_we) begin
        check("wr_addr", wb_mem_address, wr_seen);
        check("wr_data", wb_mem_data_in, wr_seen < len ? want_q[wr_seen] : 32'hFFFF_FFFF);
        wr_seen++;
      end
      if (prev_stall) begin
        check("hold_valid", wb_out_valid, 1);
        check("hold_data", wb_out_data, prev_data);
      end
      if (wb_err) check("no_err", wb_err, 0);
      if (dones > 0 && !wb_done) fin = 1;
      if (wb_done) dones++;
      if (abort2 && rd_seen == 1 && wb_out_valid) begin
        wb_reset_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        #1 wb_reset_n = 1'b1;
        fin = 1;
      end else begin
        wb_start = (cyc == start_at);
        wb_length = 7'd9;
        wb_res_valid = (cyc % gap) == 0;
        wb_res_data = sent < len ? want_q[sent] : 32'hDEAD_BEEF;
        if (wb_res_valid && wb_res_ready) begin
          last_hs = sent == len - 1;
          sent++;
        end
        wb_out_ready = toggle_rdy ? cyc[0] : 1'b1;
        prev_stall = wb_out_valid && !wb_out_ready;
        prev_data = wb_out_data;
        if (wb_out_valid && wb_out_ready) begin
          if (rd_seen < len) check("out_data", wb_out_data, want_q[rd_seen]);
          else check("extra_out", 1, 0);
          rd_seen++;
        end
      end
    end
    wb_start = 1'b0;
    wb_res_valid = 1'b0;
    wb_out_ready = 1'b0;
    if (!abort2) begin
      check("finished", fin, 1);
      check("writes", wr_seen, len);
      check("words_out", rd_seen, len);
      check("done_pulses", dones, 1);
    end
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    @(negedge wb_clk);
    wb_reset_n = 1'b1;
    @(negedge wb_clk);
    check_idle_outputs("post_reset");
    run_burst(4, 1, 0, -1, 0, 32'hA000_0000);
    @(negedge wb_clk);
    wb_start = 1'b1;
    wb_length = 7'd0;
    @(negedge wb_clk);
    wb_start = 1'b0;
    wb_res_valid = 1'b1;
    check("err_pulse", wb_err, 1);
    check("err_rdy", wb_res_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk);
      check("err_quiet", {wb_err, wb_res_ready, wb_mem_we, wb_done, wb_out_valid}, 0);
    end
    wb_res_valid = 1'b0;
    run_burst(3, 3, 1, -1, 0, 32'hB100_0010);
    run_burst(127, 1, 0, -1, 0, 32'hC7C7_0000);
    run_burst(3, 1, 0, -1, 1, 32'hD000_00D0);
    @(negedge wb_clk);
    check_idle_outputs("after_abort");
    run_burst(2, 1, 0, -1, 0, 32'hE200_0E20);
    run_burst(4, 2, 0, 3, 0, 32'hF400_F004);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
